// File: rtl/i_fetch.sv
// i_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC and drives a single-outstanding request/ready instruction
// memory port. Loads the IF/ID register that feeds decode. Follows decode's
// stall controls and redirects. A redirect that arrives while a request is
// still pending is parked in saved_target. The fetch then moves to DROP,
// where it waits for the abandoned request to finish before jumping.
module i_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'h0000_0004
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        branchTaken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_saved_target;
  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_seq;
  logic        w_take_instr;

  // Branch wins over jump when decode raises both in the same cycle.
  assign w_redirect = branchTaken | jump;
  assign w_target   = branchTaken ? branch_target : jump_target;
  assign w_seq      = r_pc + PC_STEP;

  // The request is live whenever the block is out of reset. It is never
  // withdrawn, so the address can stay stable until ready is seen.
  assign imem_req  = RST;
  assign imem_addr = r_pc;

  assign instruction_out = r_instr;
  assign npc_out         = r_npc;
  assign valid_out       = r_valid;

  // Decide whether the word on imem_rdata is a real, on-path instruction.
  always_comb begin
    w_take_instr = 1'b0;
    if ((r_state == ST_FETCH) && PCWrite && imem_ready && !w_redirect) begin
      w_take_instr = 1'b1;
    end else begin
      w_take_instr = 1'b0;
    end
  end

  // PC / fetch FSM: advance, redirect, or park the target until the pending request ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= ST_FETCH;
      r_pc           <= RESET_PC;
      r_saved_target <= 32'h0000_0000;
    end else if (PCWrite) begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_pc <= w_redirect ? w_target : w_seq;
          end else if (w_redirect) begin
            // The request must finish at its current address, so keep pc.
            r_saved_target <= w_target;
            r_state        <= ST_DROP;
          end else begin
            r_pc <= r_pc;
          end
        end
        ST_DROP: begin
          if (imem_ready) begin
            // Abandoned data is discarded. A fresh redirect beats the parked one.
            r_pc    <= w_redirect ? w_target : r_saved_target;
            r_state <= ST_FETCH;
          end else if (w_redirect) begin
            r_saved_target <= w_target;
          end else begin
            r_saved_target <= r_saved_target;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end else begin
      // Load-use stall: hold everything. Decode re-presents any redirect.
      r_state        <= r_state;
      r_pc           <= r_pc;
      r_saved_target <= r_saved_target;
    end
  end

  // IF/ID register: load the fetched word or a bubble, or hold when decode stalls it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_instr <= NOP_INSTR;
      r_npc   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (IFIDWrite) begin
      r_npc <= w_seq;
      if (w_take_instr) begin
        r_instr <= imem_rdata;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end else begin
      r_instr <= r_instr;
      r_npc   <= r_npc;
      r_valid <= r_valid;
    end
  end

endmodule
